// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP sequential engine.
// Contents: bus address map, CTRL bit positions, FSM state encoding and a
// helper that builds the fixed-point value 1.0 for a given fraction width.
package mlp_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_TOPO   = 3'd1;
  localparam logic [2:0] ADDR_INPUT  = 3'd2;
  localparam logic [2:0] ADDR_WADDR  = 3'd3;
  localparam logic [2:0] ADDR_WDATA  = 3'd4;
  localparam logic [2:0] ADDR_OUTSEL = 3'd5;
  localparam logic [2:0] ADDR_OUTPUT = 3'd6;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_DONE      = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_RELU_LAST = 3;
  localparam int CTRL_ERR       = 4;
  localparam int CTRL_BUSY      = 5;
  localparam int CTRL_SAT       = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_WB,
    S_DONE
  } state_t;

  localparam int DEF_FRAC_BITS = 8;
  localparam int Q_ONE         = 1 << DEF_FRAC_BITS;

  // 1.0 in a Q format with the given number of fractional bits.
  function automatic int q_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Multiply-accumulate datapath for the MLP engine.
// Holds the accumulator, rescales it back to the activation format and
// applies the activation function.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero the accumulator (start of a neuron)
//   en           add w*x into the accumulator
//   w, x         signed weight and input operands
//   relu         1 = ReLU, 0 = identity
//   result       activation of the accumulated neuron
//   sat          result was clipped this cycle (always 0 without MLP_SAT_EN)
// Configuration macro: MLP_SAT_EN selects saturating instead of wrapping results.
module mlp_mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic                         relu,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         sat
);

  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [ACC_WIDTH-1:0]    act_v;

  assign prod = w * x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
  end

`ifdef MLP_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  // Activation is applied on the full-width value before narrowing, so a
  // large negative sum under ReLU gives 0 rather than a wrapped positive.
  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (relu && shifted[ACC_WIDTH-1]) begin
      act_v = '0;
    end else begin
      act_v = shifted;
    end
    sat = 1'b0;
`ifdef MLP_SAT_EN
    if (act_v > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
      sat    = 1'b1;
    end else if (act_v < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
      sat    = 1'b1;
    end else begin
      result = act_v[DATA_WIDTH-1:0];
    end
`else
    result = DATA_WIDTH'(act_v);
`endif
  end

endmodule

// File: rtl/mlp_seq_engine.sv
// Bus-programmed multi-layer perceptron built around one shared MAC unit.
// Software loads topology, weights and inputs through a small register
// window, writes CTRL.run, and is told of completion through CTRL.done/irq.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   write_en     bus write strobe
//   addr         register address (see mlp_pkg)
//   writedata    bus write data
//   readdata     registered read data, valid one cycle after addr
//   irq          CTRL.irq_en & CTRL.done
// Configuration macro: MLP_SAT_EN (saturating results, sticky CTRL[6]).
module mlp_seq_engine
  import mlp_pkg::*;
#(
  parameter int N_LAYERS    = 3,
  parameter int MAX_NEURONS = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_WIDTH   = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_en,
  input  logic [2:0]  addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int TOPO_W    = 4 * (N_LAYERS + 1);
  localparam int RAM_DEPTH = N_LAYERS * MAX_NEURONS * (MAX_NEURONS + 1);
  localparam int AW        = $clog2(RAM_DEPTH);
  localparam int NW        = $clog2(MAX_NEURONS);
  localparam int LW        = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int CW        = 4;
  localparam logic FINAL_BANK = ((N_LAYERS - 1) % 2) == 1;
  localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(q_one(FRAC_BITS));

  state_t                        state;
  logic [LW-1:0]                 layer;
  logic [NW-1:0]                 neuron;
  logic [CW-1:0]                 col;
  logic                          busy, done, err, sat_flag, irq_en, relu_last;
  logic [TOPO_W-1:0]             topo;
  logic [NW-1:0]                 in_idx, outsel;
  logic [AW-1:0]                 wptr;
  logic signed [DATA_WIDTH-1:0]  wram    [RAM_DEPTH];
  logic signed [DATA_WIDTH-1:0]  in_buf  [MAX_NEURONS];
  logic signed [DATA_WIDTH-1:0]  act_buf [2][MAX_NEURONS];
  logic signed [DATA_WIDTH-1:0]  w_q, x_sel, mac_result;
  logic                          mac_sat, mac_clear, mac_en, relu_now, topo_ok;
  logic [3:0]                    fan_in, layer_size;
  logic                          wr_ctrl, wr_topo, wr_input, wr_waddr, wr_wdata, wr_outsel, run_req;
  int                            base, rd_addr_i;
  logic [31:0]                   rd_mux;
  logic                          unused_wd;

  // Field 0 of TOPO is the network input count; field l+1 is layer l's size,
  // which makes field l the fan-in of layer l.
  function automatic logic [3:0] topo_field(input logic [TOPO_W-1:0] t, input int idx);
    return t[4*idx +: 4];
  endfunction

  assign wr_ctrl   = write_en && (addr == ADDR_CTRL);
  assign wr_topo   = write_en && (addr == ADDR_TOPO);
  assign wr_input  = write_en && (addr == ADDR_INPUT);
  assign wr_waddr  = write_en && (addr == ADDR_WADDR);
  assign wr_wdata  = write_en && (addr == ADDR_WDATA);
  assign wr_outsel = write_en && (addr == ADDR_OUTSEL);
  assign run_req   = wr_ctrl && writedata[CTRL_RUN];
  assign unused_wd = ^writedata;

  assign fan_in     = topo_field(topo, int'(layer));
  assign layer_size = topo_field(topo, int'(layer) + 1);
  assign irq        = irq_en & done;

  always_comb begin
    topo_ok = 1'b1;
    for (int i = 0; i <= N_LAYERS; i++) begin
      if (topo_field(topo, i) == 4'd0 || topo_field(topo, i) > 4'(MAX_NEURONS)) begin
        topo_ok = 1'b0;
      end
    end
  end

  // LOAD presents column 0; each MAC cycle prefetches the next column so the
  // synchronous RAM read lines up with the matching input.
  always_comb begin
    base = (int'(layer) * MAX_NEURONS + int'(neuron)) * (MAX_NEURONS + 1);
    if (state == S_LOAD) begin
      rd_addr_i = base;
    end else begin
      rd_addr_i = base + int'(col) + 1;
    end
  end

  // Column 0 is the bias term; layer 0 reads the host inputs, later layers
  // read the bank written by the previous layer.
  always_comb begin
    if (col == '0) begin
      x_sel = ONE;
    end else if (layer == '0) begin
      x_sel = in_buf[NW'(col - CW'(1))];
    end else begin
      x_sel = act_buf[~layer[0]][NW'(col - CW'(1))];
    end
  end

  assign mac_clear = (state == S_LOAD);
  assign mac_en    = (state == S_MAC);
  assign relu_now  = (int'(layer) != N_LAYERS - 1) || relu_last;

  mlp_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_clear),
    .en    (mac_en),
    .w     (w_q),
    .x     (x_sel),
    .relu  (relu_now),
    .result(mac_result),
    .sat   (mac_sat)
  );

  // Weight RAM: one host write port, one engine read port, not reset.
  always_ff @(posedge clk) begin
    if (wr_wdata && !busy && wptr < AW'(RAM_DEPTH)) begin
      wram[wptr] <= writedata[DATA_WIDTH-1:0];
    end
    if (rd_addr_i < RAM_DEPTH) begin
      w_q <= wram[AW'(rd_addr_i)];
    end
  end

  // Input and ping-pong activation buffers, not reset.
  always_ff @(posedge clk) begin
    if (state == S_WB) begin
      act_buf[layer[0]][neuron] <= mac_result;
    end
    if (wr_input && !busy) begin
      in_buf[in_idx] <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Host-side configuration registers and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      topo      <= '0;
      in_idx    <= '0;
      wptr      <= '0;
      outsel    <= '0;
      irq_en    <= 1'b0;
      relu_last <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en    <= writedata[CTRL_IRQ_EN];
        relu_last <= writedata[CTRL_RELU_LAST];
      end
      if (!busy) begin
        if (wr_topo)  topo   <= writedata[TOPO_W-1:0];
        if (wr_input) in_idx <= in_idx + NW'(1);
        if (wr_waddr) wptr   <= writedata[AW-1:0];
        if (wr_wdata) wptr   <= (wptr == AW'(RAM_DEPTH - 1)) ? '0 : wptr + AW'(1);
      end
      if (run_req) in_idx <= '0;
      if (wr_outsel) outsel <= writedata[NW-1:0];
    end
  end

  // Sequencer. The W1C of done is evaluated first so that an engine-side set
  // in the same cycle takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      layer    <= '0;
      neuron   <= '0;
      col      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (wr_ctrl && writedata[CTRL_DONE]) done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (run_req) begin
            if (topo_ok) begin
              state    <= S_LOAD;
              layer    <= '0;
              neuron   <= '0;
              busy     <= 1'b1;
              err      <= 1'b0;
              sat_flag <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          col   <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          col <= col + CW'(1);
          if (col == fan_in) state <= S_WB;
        end
        S_WB: begin
          if (mac_sat) sat_flag <= 1'b1;
          if (4'(neuron) == layer_size - 4'd1) begin
            neuron <= '0;
            if (int'(layer) == N_LAYERS - 1) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              layer <= layer + LW'(1);
              state <= S_LOAD;
            end
          end else begin
            neuron <= neuron + NW'(1);
            state  <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL:   rd_mux = 32'({sat_flag, busy, err, relu_last, irq_en, done, 1'b0});
      ADDR_TOPO:   rd_mux = 32'(topo);
      ADDR_WADDR:  rd_mux = 32'(wptr);
      ADDR_OUTSEL: rd_mux = 32'(outsel);
      ADDR_OUTPUT: begin
        if (4'(outsel) < topo_field(topo, N_LAYERS)) begin
          rd_mux = 32'(act_buf[FINAL_BANK][outsel]);
        end
      end
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed self-checking bench for mlp_seq_engine (works with or without MLP_SAT_EN).
module tb_mlp_seq_engine;
  import mlp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mlp_seq_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_en (write_en),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    write_en  = 1'b1;
    addr      = a;
    writedata = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    write_en = 1'b0;
    addr     = a;
    @(posedge clk);
    #1;
    d = readdata;
  endtask

  task automatic write_neuron(input int l, input int n, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2);
    bus_write(ADDR_WADDR, 32'((l * 8 + n) * 9));
    bus_write(ADDR_WDATA, {16'h0, w0});
    bus_write(ADDR_WDATA, {16'h0, w1});
    bus_write(ADDR_WDATA, {16'h0, w2});
  endtask

  // Start a run and count clock edges until irq rises; -1 if it never does.
  task automatic run_wait(input logic [31:0] ctrl, output int cyc);
    bus_write(ADDR_CTRL, ctrl);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        cyc = i;
        break;
      end
    end
  endtask

  // 2-input, 2-2-1 network with identity hidden layers, output = x0 + x1.
  task automatic load_identity_net();
    bus_write(ADDR_TOPO, 32'h0000_1222);
    write_neuron(0, 0, 16'h0000, 16'h0100, 16'h0000);
    write_neuron(0, 1, 16'h0000, 16'h0000, 16'h0100);
    write_neuron(1, 0, 16'h0000, 16'h0100, 16'h0000);
    write_neuron(1, 1, 16'h0000, 16'h0000, 16'h0100);
    write_neuron(2, 0, 16'h0000, 16'h0100, 16'h0100);
    bus_write(ADDR_INPUT, 32'h0000_0100);
    bus_write(ADDR_INPUT, 32'h0000_0200);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    else n_pass++;
    n_checks++;
    if (readdata !== 32'h0) $display("[TB] FAIL reset_readdata: got 0x%08h expected 0x00000000", readdata);
    else n_pass++;
    bus_read(ADDR_CTRL, d);
    n_checks++;
    if (d !== 32'h0) $display("[TB] FAIL reset_ctrl: got 0x%08h expected 0x00000000", d);
    else n_pass++;
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0) $display("[TB] FAIL reset_output: got 0x%08h expected 0x00000000", d);
    else n_pass++;
  endtask

  task automatic test_identity_net();
    logic [31:0] d;
    int cyc;
    load_identity_net();
    run_wait(32'h7, cyc);
    n_checks++;
    if (cyc !== 25) $display("[TB] FAIL ident_latency: got %0d expected 25", cyc);
    else n_pass++;
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0000_0300) $display("[TB] FAIL ident_output: got 0x%08h expected 0x00000300", d);
    else n_pass++;
    bus_read(ADDR_CTRL, d);
    n_checks++;
    if (d !== 32'h0000_0006) $display("[TB] FAIL ident_ctrl: got 0x%08h expected 0x00000006", d);
    else n_pass++;
    bus_write(ADDR_OUTSEL, 32'd1);
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0) $display("[TB] FAIL outsel_range: got 0x%08h expected 0x00000000", d);
    else n_pass++;
    bus_write(ADDR_OUTSEL, 32'd0);
  endtask

  task automatic test_relu();
    logic [31:0] d;
    int cyc;
    write_neuron(0, 0, 16'hFF00, 16'h0000, 16'h0000);
    write_neuron(2, 0, 16'hFF80, 16'h0100, 16'h0000);
    run_wait(32'h7, cyc);
    n_checks++;
    if (cyc !== 25) $display("[TB] FAIL relu_latency: got %0d expected 25", cyc);
    else n_pass++;
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'hFFFF_FF80) $display("[TB] FAIL relu_hidden_identity_last: got 0x%08h expected 0xffffff80", d);
    else n_pass++;
    run_wait(32'hF, cyc);
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0) $display("[TB] FAIL relu_last: got 0x%08h expected 0x00000000", d);
    else n_pass++;
  endtask

  task automatic test_error_and_busy();
    logic [31:0] d;
    int cyc;
    bus_write(ADDR_CTRL, 32'h2);
    bus_write(ADDR_TOPO, 32'h0000_1022);
    bus_write(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus_read(ADDR_CTRL, d);
      n_checks++;
      if (d !== 32'h0000_0010) $display("[TB] FAIL err_ctrl_%0d: got 0x%08h expected 0x00000010", i, d);
      else n_pass++;
    end
    n_checks++;
    if (irq !== 1'b0) $display("[TB] FAIL err_irq: got %b expected 0", irq);
    else n_pass++;

    load_identity_net();
    bus_write(ADDR_WADDR, 32'd145);
    bus_write(ADDR_CTRL, 32'h7);
    bus_write(ADDR_WDATA, 32'h0000_0000);
    bus_write(ADDR_INPUT, 32'h0000_0700);
    bus_write(ADDR_CTRL, 32'h5);
    bus_read(ADDR_CTRL, d);
    n_checks++;
    if (d !== 32'h0000_0024) $display("[TB] FAIL busy_ctrl: got 0x%08h expected 0x00000024", d);
    else n_pass++;
    cyc = -1;
    for (int i = 5; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        cyc = i;
        break;
      end
    end
    n_checks++;
    if (cyc !== 25) $display("[TB] FAIL busy_run_latency: got %0d expected 25", cyc);
    else n_pass++;
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0000_0300) $display("[TB] FAIL busy_wdata_ignored: got 0x%08h expected 0x00000300", d);
    else n_pass++;
    run_wait(32'h7, cyc);
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0000_0300) $display("[TB] FAIL busy_input_ignored: got 0x%08h expected 0x00000300", d);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic [31:0] exp_out, exp_ctrl;
    int cyc;
`ifdef MLP_SAT_EN
    exp_out  = 32'h0000_7FFF;
    exp_ctrl = 32'h0000_0046;
`else
    exp_out  = 32'h0000_1000;
    exp_ctrl = 32'h0000_0006;
`endif
    bus_write(ADDR_CTRL, 32'h2);
    bus_write(ADDR_TOPO, 32'h0000_1111);
    write_neuron(0, 0, 16'h0000, 16'h0100, 16'h0000);
    write_neuron(1, 0, 16'h0000, 16'h6400, 16'h0000);
    write_neuron(2, 0, 16'h0000, 16'h0100, 16'h0000);
    bus_write(ADDR_INPUT, 32'h0000_6400);
    run_wait(32'h7, cyc);
    n_checks++;
    if (cyc !== 12) $display("[TB] FAIL sat_latency: got %0d expected 12", cyc);
    else n_pass++;
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== exp_out) $display("[TB] FAIL sat_output: got 0x%08h expected 0x%08h", d, exp_out);
    else n_pass++;
    bus_read(ADDR_CTRL, d);
    n_checks++;
    if (d !== exp_ctrl) $display("[TB] FAIL sat_ctrl: got 0x%08h expected 0x%08h", d, exp_ctrl);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    int cyc;
    load_identity_net();
    bus_write(ADDR_CTRL, 32'h7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (irq !== 1'b0) $display("[TB] FAIL midrst_irq: got %b expected 0", irq);
    else n_pass++;
    bus_read(ADDR_CTRL, d);
    n_checks++;
    if (d !== 32'h0) $display("[TB] FAIL midrst_ctrl: got 0x%08h expected 0x00000000", d);
    else n_pass++;
    bus_write(ADDR_TOPO, 32'h0000_1222);
    run_wait(32'h5, cyc);
    n_checks++;
    if (cyc !== 25) $display("[TB] FAIL rerun_latency: got %0d expected 25", cyc);
    else n_pass++;
    bus_read(ADDR_OUTPUT, d);
    n_checks++;
    if (d !== 32'h0000_0300) $display("[TB] FAIL rerun_output: got 0x%08h expected 0x00000300", d);
    else n_pass++;
    n_checks++;
    if (irq !== 1'b1) $display("[TB] FAIL irq_high: got %b expected 1", irq);
    else n_pass++;
    bus_write(ADDR_CTRL, 32'h6);
    n_checks++;
    if (irq !== 1'b0) $display("[TB] FAIL irq_w1c: got %b expected 0", irq);
    else n_pass++;
    bus_read(ADDR_CTRL, d);
    n_checks++;
    if (d !== 32'h0000_0004) $display("[TB] FAIL w1c_ctrl: got 0x%08h expected 0x00000004", d);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] starting mlp_seq_engine bench");
    test_reset();
    test_identity_net();
    test_relu();
    test_error_and_busy();
    test_saturation();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
